// File: rtl/ram_bit_serializer_pkg.sv
// Shared definitions for the pattern-RAM bit serializer.
// RAM_BIT_SERIALIZER_LAST_EN widens the output buffer so that a last-bit flag
// travels with each data bit.
package ram_bit_serializer_pkg;

  localparam int DEF_ADDR_W = 15;
  localparam int DEF_SIZE_W = 16;
  localparam int DEF_REP_W  = 8;

  // The output buffer is a two-entry skid.
  localparam int BUF_DEPTH = 2;
  localparam int BUF_CNT_W = $clog2(BUF_DEPTH + 1);

`ifdef RAM_BIT_SERIALIZER_LAST_EN
  localparam int BUF_W = 2;
`else
  localparam int BUF_W = 1;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/ram_bit_serializer_if.sv
// RAM 1-bit read port and serial output stream of the bit serializer.
// RAM_BIT_SERIALIZER_LAST_EN adds the SER_LAST sideband signal.
interface ram_bit_serializer_if
  import ram_bit_serializer_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);

  logic [ADDR_W-1:0] MEM_ADDR;
  logic              MEM_EN;
  logic              MEM_DO;
  logic              SER_DATA;
  logic              SER_VALID;
  logic              SER_READY;
`ifdef RAM_BIT_SERIALIZER_LAST_EN
  logic              SER_LAST;
`endif

  // Serializer side: drives RAM address/enable and the serial stream.
  modport master (
    input  MEM_DO, SER_READY,
`ifdef RAM_BIT_SERIALIZER_LAST_EN
    output SER_LAST,
`endif
    output MEM_ADDR, MEM_EN, SER_DATA, SER_VALID
  );

  // RAM and downstream side.
  modport slave (
    output MEM_DO, SER_READY,
`ifdef RAM_BIT_SERIALIZER_LAST_EN
    input  SER_LAST,
`endif
    input  MEM_ADDR, MEM_EN, SER_DATA, SER_VALID
  );

endinterface

// File: rtl/ram_bit_serializer_skid.sv
// Two-entry valid/ready output buffer. Entry 0 is always the head, so the
// output data is a plain register and stays stable while stalled. The
// producer is credit-controlled and never pushes into a full buffer.
module ram_bit_skid
  import ram_bit_serializer_pkg::*;
#(
  parameter int W = 1
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 flush,
  input  logic                 in_vld,
  input  logic [W-1:0]         in_data,
  output logic                 out_vld,
  output logic [W-1:0]         out_data,
  input  logic                 out_rdy,
  output logic [BUF_CNT_W-1:0] count
);

  logic [W-1:0]         ent0;
  logic [W-1:0]         ent1;
  logic [BUF_CNT_W-1:0] cnt;
  logic                 pop;

  assign pop      = out_vld & out_rdy;
  assign out_vld  = (cnt != '0);
  assign out_data = ent0;
  assign count    = cnt;

  // Push/pop bookkeeping; flush drops everything held in one cycle.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cnt  <= '0;
      ent0 <= '0;
      ent1 <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      case (cnt)
        BUF_CNT_W'(0): begin
          if (in_vld) begin
            ent0 <= in_data;
            cnt  <= BUF_CNT_W'(1);
          end
        end
        BUF_CNT_W'(1): begin
          case ({in_vld, pop})
            2'b10: begin
              ent1 <= in_data;
              cnt  <= BUF_CNT_W'(2);
            end
            2'b01: cnt <= BUF_CNT_W'(0);
            2'b11: ent0 <= in_data;
            default: ;
          endcase
        end
        BUF_CNT_W'(2): begin
          if (pop) begin
            ent0 <= ent1;
            if (in_vld) ent1 <= in_data;
            else        cnt  <= BUF_CNT_W'(1);
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: rtl/ram_bit_serializer.sv
// Read side of the byte-write / bit-read pattern memory: walks bit addresses
// START..START+SIZE-1 for the configured number of repetitions and streams
// one bit per transfer. RAM_BIT_SERIALIZER_LAST_EN adds SER_LAST, marking
// the final bit of each repetition.
module ram_bit_serializer
  import ram_bit_serializer_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int SIZE_W = DEF_SIZE_W,
  parameter int REP_W  = DEF_REP_W
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 START,
  input  logic                 STOP,
  input  logic [ADDR_W-1:0]    CONF_ADDR,
  input  logic [SIZE_W-1:0]    CONF_SIZE,
  input  logic [REP_W-1:0]     CONF_REPEAT,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [REP_W-1:0]     REP_CNT,
  ram_bit_serializer_if.master bus
);

  state_t               state;
  logic [ADDR_W-1:0]    addr_p0;
  logic [ADDR_W-1:0]    cfg_addr;
  logic [SIZE_W-1:0]    cfg_size;
  logic [SIZE_W-1:0]    rem;
  logic [REP_W-1:0]     cfg_rep;
  logic [REP_W-1:0]     rep_cnt;
  logic [REP_W-1:0]     rep_sat;
  logic [REP_W:0]       rep_next_w;
  logic                 busy;
  logic                 done;
  logic                 vld_p1;
  logic                 accept;
  logic                 rd_en;
  logic                 rd_last;
  logic                 rep_final;
  logic                 pop;
  logic                 buf_room;
  logic                 buf_vld;
  logic [BUF_CNT_W-1:0] buf_cnt;
  logic [BUF_W-1:0]     buf_in;
  logic [BUF_W-1:0]     buf_out;

  assign accept = START & ~STOP & ~busy & (state == ST_IDLE) & (CONF_SIZE != '0);

  // A read may issue only if the buffer will still have a slot when its data
  // lands, counting the read already in flight and this cycle's pop.
  assign pop      = buf_vld & bus.SER_READY;
  assign buf_room = (int'(buf_cnt) + int'(vld_p1)) <= (1 + int'(pop));
  assign rd_en    = (state == ST_RUN) & ~STOP & buf_room;
  assign rd_last  = (rem == SIZE_W'(1));

  assign rep_next_w = {1'b0, rep_cnt} + (REP_W+1)'(1);
  assign rep_sat    = (&rep_cnt) ? rep_cnt : rep_next_w[REP_W-1:0];
  assign rep_final  = (cfg_rep != '0) && (rep_next_w == {1'b0, cfg_rep});

  // Job configuration is captured once at START; later changes are ignored.
  always_ff @(posedge CLK) begin
    if (accept) begin
      cfg_addr <= CONF_ADDR;
      cfg_size <= CONF_SIZE;
      cfg_rep  <= CONF_REPEAT;
    end
  end

  // Control FSM and read sequencer (stage p0: address issue, p1: data back).
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state   <= ST_IDLE;
      addr_p0 <= '0;
      rem     <= '0;
      rep_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      done   <= 1'b0;
      vld_p1 <= rd_en;
      if (STOP) begin
        state  <= ST_IDLE;
        busy   <= 1'b0;
        vld_p1 <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            // BUSY falls the cycle after the DONE pulse.
            if (done) busy <= 1'b0;
            if (accept) begin
              state   <= ST_RUN;
              busy    <= 1'b1;
              addr_p0 <= CONF_ADDR;
              rem     <= CONF_SIZE;
              rep_cnt <= '0;
            end
          end
          ST_RUN: begin
            if (rd_en) begin
              if (rd_last) begin
                // Repetition complete: reload without a gap cycle.
                rep_cnt <= rep_sat;
                rem     <= cfg_size;
                addr_p0 <= cfg_addr;
                if (rep_final) state <= ST_DRAIN;
              end else begin
                rem     <= rem - SIZE_W'(1);
                addr_p0 <= addr_p0 + ADDR_W'(1);
              end
            end
          end
          ST_DRAIN: begin
            if ((buf_cnt == '0) && !vld_p1) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef RAM_BIT_SERIALIZER_LAST_EN
  logic last_p1;

  // Last-bit flag follows its read into the data stage.
  always_ff @(posedge CLK) begin
    if (!RST_N) last_p1 <= 1'b0;
    else        last_p1 <= rd_en & rd_last;
  end

  assign buf_in       = {last_p1, bus.MEM_DO};
  assign bus.SER_LAST = buf_out[1];
`else
  assign buf_in = bus.MEM_DO;
`endif

  ram_bit_skid #(
    .W (BUF_W)
  ) u_skid (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .flush    (STOP),
    .in_vld   (vld_p1),
    .in_data  (buf_in),
    .out_vld  (buf_vld),
    .out_data (buf_out),
    .out_rdy  (bus.SER_READY),
    .count    (buf_cnt)
  );

  assign bus.MEM_ADDR  = addr_p0;
  assign bus.MEM_EN    = rd_en;
  assign bus.SER_DATA  = buf_out[0];
  assign bus.SER_VALID = buf_vld;
  assign BUSY          = busy;
  assign DONE          = done;
  assign REP_CNT       = rep_cnt;

endmodule

// File: tb/tb_ram_bit_serializer.sv
// Testbench for ram_bit_serializer: byte-organised RAM model on the 1-bit
// read port, randomized READY and job configs, queue-based expected stream.
// RAM_BIT_SERIALIZER_LAST_EN additionally checks SER_LAST.
module tb_ram_bit_serializer;
  import ram_bit_serializer_pkg::*;

  localparam int AW     = DEF_ADDR_W;
  localparam int SW     = DEF_SIZE_W;
  localparam int RW     = DEF_REP_W;
  localparam int NBYTES = 1 << (AW - 3);

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          START = 1'b0;
  logic          STOP = 1'b0;
  logic [AW-1:0] CONF_ADDR = '0;
  logic [SW-1:0] CONF_SIZE = '0;
  logic [RW-1:0] CONF_REPEAT = '0;
  logic          BUSY;
  logic          DONE;
  logic [RW-1:0] REP_CNT;
  logic          rdy = 1'b1;
  logic          rd_q = 1'b0;

  logic [7:0] ram [NBYTES];
  bit         exp_q[$];
  bit         last_q[$];
  int         checks = 0;
  int         errors = 0;

  ram_bit_serializer_if #(.ADDR_W(AW)) bus ();

  ram_bit_serializer #(
    .ADDR_W (AW),
    .SIZE_W (SW),
    .REP_W  (RW)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .START       (START),
    .STOP        (STOP),
    .CONF_ADDR   (CONF_ADDR),
    .CONF_SIZE   (CONF_SIZE),
    .CONF_REPEAT (CONF_REPEAT),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .REP_CNT     (REP_CNT),
    .bus         (bus)
  );

  always #5 CLK = ~CLK;

  // Bit address {byte, lane}: lane i is bit i of the byte.
  function automatic logic ram_bit(input logic [AW-1:0] a);
    return ram[a[AW-1:3]][a[2:0]];
  endfunction

  // RAM 1-bit port: data appears one cycle after the enable.
  always @(posedge CLK) if (bus.MEM_EN) rd_q <= ram_bit(bus.MEM_ADDR);
  assign bus.MEM_DO    = rd_q;
  assign bus.SER_READY = rdy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic build_exp(input int addr, input int size, input int reps);
    exp_q.delete();
    last_q.delete();
    for (int r = 0; r < reps; r++)
      for (int i = 0; i < size; i++) begin
        exp_q.push_back(ram_bit(AW'(addr + i)));
        last_q.push_back(i == size - 1);
      end
  endtask

  task automatic pulse_start(input int addr, input int size, input int rep);
    @(posedge CLK); #1;
    rdy = 1'b1;
    START = 1'b1;
    CONF_ADDR = AW'(addr);
    CONF_SIZE = SW'(size);
    CONF_REPEAT = RW'(rep);
    @(posedge CLK); #1;
    START = 1'b0;
    CONF_ADDR = AW'($urandom);
    CONF_SIZE = SW'($urandom_range(1, 50));
    CONF_REPEAT = RW'($urandom);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_outs"}, {bus.MEM_EN, bus.SER_VALID, bus.SER_DATA, BUSY, DONE}, 0);
    check({tag, "_addr"}, bus.MEM_ADDR, 0);
    check({tag, "_rep"}, REP_CNT, 0);
  endtask

  // mode 0: READY high, 1: random. stop_after>0 aborts after that many
  // transfers; rc_exp<0 means REP_CNT must hold across the STOP.
  task automatic run_job(input string name, input int mode, input int stop_after,
                         input bit poke, input int rc_exp);
    int          it = 0;
    int          first = -1;
    int          lastx = -1;
    int          xf = 0;
    int          dones = 0;
    int          budget;
    bit          stall = 0;
    bit          fin = 0;
    bit          noisy = 0;
    logic        pdata = 1'b0;
    logic [RW-1:0] rc_hold = '0;
    budget = 8 * exp_q.size() + 60;
    while (!fin && it < budget) begin
      @(negedge CLK);
      if (it == 0) check({name, "_busy_on"}, BUSY, 1);
      if (stall) begin
        check({name, "_stall_vld"}, bus.SER_VALID, 1);
        check({name, "_stall_data"}, bus.SER_DATA, pdata);
      end
      if (bus.SER_VALID && first < 0) first = it;
      if (DONE) dones++;
      if (bus.SER_VALID && bus.SER_READY) begin
        if (exp_q.size() == 0) check({name, "_extra"}, 1, 0);
        else begin
          check({name, "_bit"}, bus.SER_DATA, exp_q.pop_front());
`ifdef RAM_BIT_SERIALIZER_LAST_EN
          check({name, "_last"}, bus.SER_LAST, last_q.pop_front());
`else
          void'(last_q.pop_front());
`endif
        end
        xf++;
        lastx = it;
      end
      stall = bus.SER_VALID && !bus.SER_READY;
      pdata = bus.SER_DATA;
      if (stop_after > 0 && xf == stop_after) begin
        STOP = 1'b1;
        rc_hold = REP_CNT;
        fin = 1;
      end else if (stop_after == 0 && dones > 0) begin
        fin = 1;
      end
      @(posedge CLK); #1;
      STOP = 1'b0;
      rdy = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      START = poke && (it == 4);
      it++;
    end
    if (!fin) check({name, "_timeout"}, 0, 1);
    check({name, "_latency"}, first, 2);
    if (stop_after == 0) begin
      @(negedge CLK);
      check({name, "_done_width"}, DONE, 0);
      check({name, "_busy_off"}, BUSY, 0);
      check({name, "_left"}, exp_q.size(), 0);
      check({name, "_rep_cnt"}, REP_CNT, rc_exp);
      if (mode == 0) check({name, "_thruput"}, lastx - first + 1, xf);
      repeat (3) begin
        @(negedge CLK);
        if (DONE) dones++;
      end
      check({name, "_done_cnt"}, dones, 1);
    end else begin
      @(negedge CLK);
      check({name, "_stop_vld"}, bus.SER_VALID, 0);
      check({name, "_stop_busy"}, BUSY, 0);
      check({name, "_stop_rep"}, REP_CNT, (rc_exp >= 0) ? 32'(rc_exp) : 32'(rc_hold));
      repeat (4) begin
        @(negedge CLK);
        if (DONE || bus.SER_VALID || bus.MEM_EN) noisy = 1;
      end
      check({name, "_stop_quiet"}, noisy, 0);
    end
  endtask

  initial begin
    int t1_bits[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    int a, s, r;
    for (int i = 0; i < NBYTES; i++) ram[i] = 8'($urandom);
    ram[0] = 8'hA5;

    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check_reset_vals("rst");
    RST_N = 1'b1;

    // Byte 0xA5 read LSB first, READY high, then with random READY.
    for (int m = 0; m < 2; m++) begin
      exp_q.delete();
      last_q.delete();
      for (int i = 0; i < 8; i++) begin
        exp_q.push_back(t1_bits[i] != 0);
        last_q.push_back(i == 7);
      end
      pulse_start(0, 8, 1);
      run_job((m == 0) ? "a5_rdy" : "a5_rand", m, 0, 0, 1);
    end

    // Address wrap from the top of the bit space.
    build_exp('h7FFC, 8, 1);
    pulse_start('h7FFC, 8, 1);
    run_job("wrap", 1, 0, 0, 1);

    // Repetitions with no gap; a START while busy is ignored.
    build_exp(5, 3, 4);
    pulse_start(5, 3, 4);
    run_job("rep4", 0, 0, 1, 4);

    // Infinite mode aborted after 20 transfers, then a fresh job.
    build_exp(100, 7, 10);
    pulse_start(100, 7, 0);
    run_job("inf_stop", 1, 20, 0, -1);
    build_exp(40, 5, 2);
    pulse_start(40, 5, 2);
    run_job("restart", 0, 0, 0, 2);

    // REP_CNT saturation in infinite mode.
    build_exp(9, 1, 320);
    pulse_start(9, 1, 0);
    run_job("sat", 0, 300, 0, 255);

    // START with SIZE 0 is ignored.
    pulse_start(0, 0, 1);
    @(negedge CLK);
    check("size0_busy", BUSY, 0);
    check("size0_vld", bus.SER_VALID, 0);

    // Random jobs.
    for (int j = 0; j < 6; j++) begin
      a = $urandom_range(0, (1 << AW) - 1);
      s = $urandom_range(1, 40);
      r = $urandom_range(1, 3);
      build_exp(a, s, r);
      pulse_start(a, s, r);
      run_job("rnd", $urandom_range(0, 1), 0, (s * r) >= 10, r);
    end

    // Reset in the middle of a run.
    build_exp(0, 30, 2);
    pulse_start(0, 30, 2);
    repeat (10) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b0;
    @(posedge CLK); #1;
    check_reset_vals("midrst");
    RST_N = 1'b1;

    // START together with STOP keeps the block idle.
    @(posedge CLK); #1;
    START = 1'b1;
    STOP = 1'b1;
    CONF_ADDR = '0;
    CONF_SIZE = SW'(8);
    CONF_REPEAT = RW'(1);
    @(posedge CLK); #1;
    START = 1'b0;
    STOP = 1'b0;
    check("startstop_busy", BUSY, 0);
    check("startstop_en", bus.MEM_EN, 0);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("startstop_vld", bus.SER_VALID, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
